apb_regfile: RTL and testbench

Parametrised APB slave register file that replaces the per-register read-only capture blocks with a single addressable bank. It holds NRO read-only status registers, captured as a coherent snapshot of hardware inputs, and NREG-NRO read/write control registers driven out to the fabric. It supports programmable wait states, address-range checking and error signalling. It sits behind the APB bridge decoder, one instance per peripheral.

---
 rtl/apb_regfile_pkg.sv | 16 +
 rtl/apb_regfile_fsm.sv | 72 +++++++
 rtl/apb_regfile.sv | 89 ++++++++
 tb/tb_apb_regfile.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_regfile_pkg.sv
// Shared types and address-decode helpers for the APB register file.
package apb_regfile_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam int WCNT_W = 4;

    function automatic logic idx_is_ro(input int unsigned idx, input int unsigned nro);
        return idx < nro;
    endfunction

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned nreg);
        return idx < nreg;
    endfunction

endpackage

// File: rtl/apb_regfile_fsm.sv
// APB transfer sequencer with a wait-state down-counter.
// state  | meaning
// IDLE   | no transfer in flight; watching for a setup phase
// SETUP  | first access cycle; counter just loaded with WAIT
// ACCESS | later access cycles; counter running down to 0
module apb_regfile_fsm
    import apb_regfile_pkg::*;
#(
    parameter int WAIT = 0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic psel,
    input  logic penable,
    output logic snap_load,
    output logic load,
    output logic complete,
    output logic abort
);

    state_t              state, state_nx;
    logic [WCNT_W-1:0]   cnt, cnt_nx;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        snap_load = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nx  = SETUP;
                    cnt_nx    = WCNT_W'(WAIT);
                    snap_load = 1'b1;
                end
            end
            default: begin
                if (!psel) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    if (!penable) begin
                        state_nx  = SETUP;
                        cnt_nx    = WCNT_W'(WAIT);
                        snap_load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx   = cnt - 1'b1;
                    state_nx = ACCESS;
                end
            end
        endcase
        // The next cycle is the completion cycle: outputs get loaded this edge.
        load = (state_nx != IDLE) && (cnt_nx == '0);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            cnt      <= '0;
            complete <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            complete <= load;
        end
    end

endmodule

// File: rtl/apb_regfile.sv
// APB register bank: NRO snapshot status registers followed by read/write controls.
module apb_regfile
    import apb_regfile_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int NREG   = 8,
    parameter int NRO    = 3,
    parameter int WAIT   = 0
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [AWIDTH-1:0]            PADDR,
    input  logic [DWIDTH-1:0]            PWDATA,
    output logic [DWIDTH-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic [NRO*DWIDTH-1:0]        status_in,
    output logic [(NREG-NRO)*DWIDTH-1:0] ctrl_out
);

    logic [DWIDTH-1:0] snap [NRO];
    logic [DWIDTH-1:0] ctrl [NREG-NRO];
    logic [DWIDTH-1:0] rd_val;
    logic              snap_load, load, complete, abort;
    logic              in_range, is_ro, wr_hit;

    apb_regfile_fsm #(.WAIT(WAIT)) u_fsm (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .psel      (PSEL),
        .penable   (PENABLE),
        .snap_load (snap_load),
        .load      (load),
        .complete  (complete),
        .abort     (abort)
    );

    assign in_range = idx_in_range(32'(PADDR), NREG);
    assign is_ro    = idx_is_ro(32'(PADDR), NRO);
    assign wr_hit   = complete && !abort && PWRITE && in_range && !is_ro;
    assign PREADY   = complete;

    // With WAIT=0 the snapshot and the read data load on the same edge, so bypass.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NRO; i++)
            if (PADDR == AWIDTH'(i))
                rd_val = snap_load ? status_in[i*DWIDTH +: DWIDTH] : snap[i];
        for (int j = 0; j < NREG-NRO; j++)
            if (PADDR == AWIDTH'(NRO+j))
                rd_val = ctrl[j];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NRO; i++) snap[i] <= '0;
        end else if (snap_load) begin
            for (int i = 0; i < NRO; i++) snap[i] <= status_in[i*DWIDTH +: DWIDTH];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int j = 0; j < NREG-NRO; j++) ctrl[j] <= '0;
        end else if (wr_hit) begin
            for (int j = 0; j < NREG-NRO; j++)
                if (PADDR == AWIDTH'(NRO+j)) ctrl[j] <= PWDATA;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else begin
            PRDATA  <= (load && !PWRITE && in_range) ? rd_val : '0;
            PSLVERR <= load && (!in_range || (PWRITE && is_ro));
        end
    end

    for (genvar g = 0; g < NREG-NRO; g++) begin : g_ctrl
        assign ctrl_out[g*DWIDTH +: DWIDTH] = ctrl[g];
    end

endmodule

// File: tb/tb_apb_regfile.sv
// Directed bench for apb_regfile: one instance with WAIT=2, one with WAIT=0.
module tb_apb_regfile;
    import apb_regfile_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [7:0]  pwdata;
    logic [23:0] status;
    logic [7:0]  prdata;
    logic        pready, pslverr;
    logic [39:0] ctrl;

    logic        psel0, penable0, pwrite0;
    logic [3:0]  paddr0;
    logic [7:0]  pwdata0;
    logic [23:0] status0;
    logic [7:0]  prdata0;
    logic        pready0, pslverr0;
    logic [39:0] ctrl0;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_ctrl;
    logic [7:0]  rd;
    logic        err;
    int          n;

    apb_regfile #(.DWIDTH(8), .AWIDTH(4), .NREG(8), .NRO(3), .WAIT(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .status_in(status), .ctrl_out(ctrl)
    );

    apb_regfile #(.DWIDTH(8), .AWIDTH(4), .NREG(8), .NRO(3), .WAIT(0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(penable0), .PWRITE(pwrite0),
        .PADDR(paddr0), .PWDATA(pwdata0), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
        .status_in(status0), .ctrl_out(ctrl0)
    );

    always #5 PCLK = ~PCLK;

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    // Full transfer on the WAIT=2 instance; n counts access cycles up to PREADY.
    task automatic apb2(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                        output logic [7:0] rdo, output logic erro, output int no);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        cyc();
        penable = 1'b1;
        no = 1;
        while (!pready && no < 10) begin
            cyc();
            no++;
        end
        rdo  = prdata;
        erro = pslverr;
        cyc();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (prdata !== 8'h00) begin errors++; $display("FAIL reset_prdata got %h want 00", prdata); end
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready got %b want 0", pready); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b want 0", pslverr); end
        checks++; if (ctrl !== 40'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ctrl); end
        checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL reset_pready0 got %b want 0", pready0); end
        checks++; if (ctrl0 !== 40'h0) begin errors++; $display("FAIL reset_ctrl0 got %h want 0", ctrl0); end
    endtask

    task automatic test_write_read();
        apb2(1'b1, 4'd5, 8'hA5, rd, err, n);
        exp_ctrl[23:16] = 8'hA5;
        checks++; if (n !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", n); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", err); end
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL wr_prdata got %h want 00", rd); end
        checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL wr_ctrl got %h want %h", ctrl, exp_ctrl); end
        apb2(1'b0, 4'd5, 8'h00, rd, err, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", n); end
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL rd_data got %h want a5", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", err); end
    endtask

    task automatic test_snapshot();
        status = 24'h332211;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'd1;
        cyc();
        penable = 1'b1;
        status  = 24'hFFFFFF;
        n = 1;
        while (!pready && n < 10) begin
            cyc();
            n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL snap_latency got %0d want 3", n); end
        checks++; if (prdata !== 8'h22) begin errors++; $display("FAIL snap_data got %h want 22", prdata); end
        cyc();
        psel = 1'b0; penable = 1'b0;
        checks++; if (prdata !== 8'h00) begin errors++; $display("FAIL snap_prdata_idle got %h want 00", prdata); end
        apb2(1'b0, 4'd1, 8'h00, rd, err, n);
        checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL snap_refresh got %h want ff", rd); end
    endtask

    task automatic test_errors();
        apb2(1'b1, 4'd2, 8'h77, rd, err, n);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ro_write_err got %b want 1", err); end
        checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL ro_write_ctrl got %h want %h", ctrl, exp_ctrl); end
        status = 24'h445566;
        apb2(1'b0, 4'd2, 8'h00, rd, err, n);
        checks++; if (rd !== 8'h44) begin errors++; $display("FAIL ro_read got %h want 44", rd); end
        apb2(1'b0, 4'd9, 8'h00, rd, err, n);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor9_err got %b want 1", err); end
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL oor9_data got %h want 00", rd); end
        apb2(1'b0, 4'd8, 8'h00, rd, err, n);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor8_err got %b want 1", err); end
        apb2(1'b0, 4'd7, 8'h00, rd, err, n);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL last_idx_err got %b want 0", err); end
        apb2(1'b1, 4'd9, 8'hEE, rd, err, n);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_write_err got %b want 1", err); end
        checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL oor_write_ctrl got %h want %h", ctrl, exp_ctrl); end
    endtask

    task automatic test_back_to_back();
        psel0 = 1'b1; penable0 = 1'b0; pwrite0 = 1'b1; paddr0 = 4'd3; pwdata0 = 8'h5C;
        cyc();
        penable0 = 1'b1;
        checks++; if (pready0 !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready got %b want 1", pready0); end
        checks++; if (pslverr0 !== 1'b0) begin errors++; $display("FAIL b2b_wr_err got %b want 0", pslverr0); end
        cyc();
        penable0 = 1'b0; pwrite0 = 1'b0;
        checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL b2b_gap_ready got %b want 0", pready0); end
        checks++; if (ctrl0 !== 40'h5C) begin errors++; $display("FAIL b2b_ctrl got %h want 5c", ctrl0); end
        cyc();
        penable0 = 1'b1;
        checks++; if (pready0 !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready got %b want 1", pready0); end
        checks++; if (prdata0 !== 8'h5C) begin errors++; $display("FAIL b2b_rd_data got %h want 5c", prdata0); end
        cyc();
        psel0 = 1'b0; penable0 = 1'b0;
        checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL b2b_end_ready got %b want 0", pready0); end
    endtask

    task automatic test_abort();
        logic seen;
        apb2(1'b1, 4'd4, 8'h11, rd, err, n);
        exp_ctrl[15:8] = 8'h11;
        checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL abort_pre_ctrl got %h want %h", ctrl, exp_ctrl); end
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd4; pwdata = 8'h99;
        cyc();
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (pready) seen = 1'b1;
            cyc();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", seen); end
        checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL abort_ctrl got %h want %h", ctrl, exp_ctrl); end
    endtask

    task automatic test_mid_reset();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd6; pwdata = 8'h3C;
        cyc();
        penable = 1'b1;
        cyc();
        PRESETn = 1'b0;
        #1;
        exp_ctrl = '0;
        checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL mrst_ctrl got %h want 0", ctrl); end
        checks++; if (ctrl0 !== 40'h0) begin errors++; $display("FAIL mrst_ctrl0 got %h want 0", ctrl0); end
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL mrst_ready got %b want 0", pready); end
        checks++; if (prdata !== 8'h00) begin errors++; $display("FAIL mrst_prdata got %h want 00", prdata); end
        psel = 1'b0; penable = 1'b0;
        #2;
        PRESETn = 1'b1;
        cyc();
        cyc();
        checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL mrst_after_ctrl got %h want 0", ctrl); end
        apb2(1'b0, 4'd5, 8'h00, rd, err, n);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mrst_read5 got %h want 00", rd); end
        checks++; if (n !== 3) begin errors++; $display("FAIL mrst_latency got %0d want 3", n); end
    endtask

    initial begin
        PRESETn  = 1'b0;
        psel     = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'd5; pwdata = 8'h5A;
        status   = 24'hABCDEF;
        psel0    = 1'b1; penable0 = 1'b0; pwrite0 = 1'b1; paddr0 = 4'd3; pwdata0 = 8'hC3;
        status0  = 24'h123456;
        exp_ctrl = '0;
        repeat (3) cyc();
        test_reset();
        psel  = 1'b0; penable  = 1'b0;
        psel0 = 1'b0; penable0 = 1'b0;
        PRESETn = 1'b1;
        cyc();
        test_write_read();
        test_snapshot();
        test_errors();
        test_back_to_back();
        test_abort();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
